// File: rtl/cache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_ctrl
// Function : Cache-miss block fill controller. It issues one read per word
//            over a valid/ready channel, streams the in-order responses into
//            the data array, and finishes with a single tag-array write.
// Option   : CACHE_FILL_CRIT_FIRST_EN requests the critical word first and
//            returns it early (early restart).
// Revision : 1.0 - initial release
// ============================================================================
module cache_fill_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        miss_detected,
  input  logic [ADDR_W-1:0]           miss_address,
  output logic                        fsm_busy,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [ADDR_W-1:0]           memory_address,
  input  logic [DATA_W-1:0]           memory_data,
  input  logic                        memory_data_valid,
  output logic                        write_data_array,
  output logic [$clog2(WORDS)-1:0]    data_array_word,
  output logic [DATA_W-1:0]           data_array_wdata,
  output logic                        write_tag_array,
  output logic [DATA_W-1:0]           miss_data,
  output logic                        miss_data_valid
);

  localparam int OFF_W  = $clog2(WORDS);
  localparam int BYTE_W = $clog2(DATA_W/8);
  localparam int TAG_W  = ADDR_W - OFF_W - BYTE_W;

  localparam logic [OFF_W:0] C_WORDS = (OFF_W+1)'(WORDS);
  localparam logic [OFF_W:0] C_LAST  = (OFF_W+1)'(WORDS-1);
  localparam logic [OFF_W:0] C_ONE   = (OFF_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [OFF_W-1:0]    crit_q, crit_d;
  logic [OFF_W:0]      iss_cnt_q, iss_cnt_d;
  logic [OFF_W:0]      ret_cnt_q, ret_cnt_d;
  logic [DATA_W-1:0]   miss_data_q, miss_data_d;

  logic [OFF_W-1:0]    start_idx;
  logic [OFF_W-1:0]    issue_idx;
  logic [OFF_W-1:0]    ret_idx;
  logic                req_fire;
  logic                resp_fire;
  logic                crit_hit;
  logic                unused_ok;

`ifdef CACHE_FILL_CRIT_FIRST_EN
  assign start_idx = crit_q;
`else
  assign start_idx = '0;
`endif

  // Word indices wrap inside OFF_W bits, so the address never carries into the tag.
  assign issue_idx = start_idx + iss_cnt_q[OFF_W-1:0];
  assign ret_idx   = start_idx + ret_cnt_q[OFF_W-1:0];

  assign fsm_busy       = (state_q != S_IDLE);
  assign mem_req_valid  = (state_q == S_FILL) && (iss_cnt_q < C_WORDS);
  assign memory_address = ADDR_W'({tag_q, issue_idx}) << BYTE_W;
  assign req_fire       = mem_req_valid && mem_req_ready;

  // A response with nothing outstanding is a protocol error and is dropped.
  assign resp_fire = (state_q == S_FILL) && memory_data_valid && (ret_cnt_q != iss_cnt_q);
  assign crit_hit  = resp_fire && (ret_idx == crit_q);

  assign write_data_array = resp_fire;
  assign data_array_word  = ret_idx;
  assign data_array_wdata = memory_data;
  assign write_tag_array  = (state_q == S_DONE);

`ifdef CACHE_FILL_CRIT_FIRST_EN
  assign miss_data_valid = crit_hit;
  assign miss_data       = crit_hit ? memory_data : miss_data_q;
`else
  assign miss_data_valid = (state_q == S_DONE);
  assign miss_data       = miss_data_q;
`endif

  assign unused_ok = &{1'b0, miss_address};

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    crit_d      = crit_q;
    iss_cnt_d   = iss_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    miss_data_d = miss_data_q;
    case (state_q)
      S_IDLE: begin
        if (miss_detected) begin
          tag_d     = miss_address[ADDR_W-1:OFF_W+BYTE_W];
          crit_d    = miss_address[OFF_W+BYTE_W-1:BYTE_W];
          iss_cnt_d = '0;
          ret_cnt_d = '0;
          state_d   = S_FILL;
        end
      end
      S_FILL: begin
        if (req_fire) begin
          iss_cnt_d = iss_cnt_q + C_ONE;
        end
        if (resp_fire) begin
          ret_cnt_d = ret_cnt_q + C_ONE;
          if (crit_hit) begin
            miss_data_d = memory_data;
          end
          if (ret_cnt_q == C_LAST) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tag_q       <= '0;
      crit_q      <= '0;
      iss_cnt_q   <= '0;
      ret_cnt_q   <= '0;
      miss_data_q <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      crit_q      <= crit_d;
      iss_cnt_q   <= iss_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      miss_data_q <= miss_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_ctrl.sv
`default_nettype none
// Testbench for cache_fill_ctrl: directed fills against a latency-4 in-order memory model.
module tb_cache_fill_ctrl;

  localparam int LAT = 4;
`ifdef CACHE_FILL_CRIT_FIRST_EN
  localparam bit CRIT_FIRST = 1'b1;
`else
  localparam bit CRIT_FIRST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy, mem_req_valid, mem_req_ready;
  logic [15:0] memory_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        write_data_array;
  logic [2:0]  data_array_word;
  logic [15:0] data_array_wdata;
  logic        write_tag_array;
  logic [15:0] miss_data;
  logic        miss_data_valid;

  logic        miss_detected2;
  logic [15:0] miss_address2;
  logic        busy2, req_valid2, req_ready2;
  logic [15:0] addr2;
  logic [31:0] mdata2;
  logic        mdv_in2;
  logic        wr2;
  logic [1:0]  widx2;
  logic [31:0] wdata2;
  logic        tag2;
  logic [31:0] missd2;
  logic        missv2;

  always #5 clk = ~clk;

  cache_fill_ctrl #(.ADDR_W(16), .DATA_W(16), .WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_detected(miss_detected), .miss_address(miss_address),
    .fsm_busy(fsm_busy), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .memory_address(memory_address), .memory_data(memory_data),
    .memory_data_valid(memory_data_valid), .write_data_array(write_data_array),
    .data_array_word(data_array_word), .data_array_wdata(data_array_wdata),
    .write_tag_array(write_tag_array), .miss_data(miss_data),
    .miss_data_valid(miss_data_valid)
  );

  cache_fill_ctrl #(.ADDR_W(16), .DATA_W(32), .WORDS(4)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .miss_detected(miss_detected2), .miss_address(miss_address2),
    .fsm_busy(busy2), .mem_req_valid(req_valid2), .mem_req_ready(req_ready2),
    .memory_address(addr2), .memory_data(mdata2),
    .memory_data_valid(mdv_in2), .write_data_array(wr2),
    .data_array_word(widx2), .data_array_wdata(wdata2),
    .write_tag_array(tag2), .miss_data(missd2),
    .miss_data_valid(missv2)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [15:0] acc_q[$];
  int          acc_cyc_q[$];
  int          wr_idx_q[$];
  logic [15:0] wr_dat_q[$];
  int          wr_cyc_q[$];
  logic [15:0] pend_a[$];
  int          pend_due[$];
  int          tag_cnt, tag_cyc, mdv_cnt, mdv_cyc, stall_err;
  logic [15:0] mdv_dat;
  bit          busy_hist[int];
  int          ready_mode = 0;
  bit          force_mdv = 1'b0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_addr = '0;

  function automatic logic [15:0] dat(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3C3;
  endfunction

  function automatic int exp_idx(input int i, input int crit, input int words);
    return CRIT_FIRST ? (crit + i) % words : i;
  endfunction

  task automatic clear_logs();
    acc_q.delete(); acc_cyc_q.delete();
    wr_idx_q.delete(); wr_dat_q.delete(); wr_cyc_q.delete();
    tag_cnt = 0; tag_cyc = 0; mdv_cnt = 0; mdv_cyc = 0; mdv_dat = '0; stall_err = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_miss(input logic [15:0] a, output int mc);
    miss_address = a; miss_detected = 1'b1; mc = cyc;
    tick(1);
    miss_detected = 1'b0;
  endtask

  task automatic wait_tag(input int n, input int budget);
    int k = 0;
    while (tag_cnt < n && k < budget) begin tick(1); k++; end
  endtask

  // Monitor on the falling edge, memory model drives just after the rising edge.
  initial begin
    mem_req_ready = 1'b1; memory_data_valid = 1'b0; memory_data = '0;
    forever begin
      @(negedge clk);
      busy_hist[cyc] = fsm_busy;
      if (prev_stall && (!mem_req_valid || memory_address !== prev_addr)) stall_err++;
      prev_stall = mem_req_valid && !mem_req_ready;
      prev_addr  = memory_address;
      if (mem_req_valid && mem_req_ready) begin
        acc_q.push_back(memory_address); acc_cyc_q.push_back(cyc);
        pend_a.push_back(memory_address); pend_due.push_back(cyc + LAT);
      end
      if (write_data_array) begin
        wr_idx_q.push_back(int'(data_array_word)); wr_dat_q.push_back(data_array_wdata);
        wr_cyc_q.push_back(cyc);
      end
      if (write_tag_array) begin tag_cnt++; tag_cyc = cyc; end
      if (miss_data_valid) begin mdv_cnt++; mdv_cyc = cyc; mdv_dat = miss_data; end
      @(posedge clk);
      cyc++;
      #1;
      mem_req_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        memory_data_valid = 1'b1; memory_data = dat(pend_a[0]);
        void'(pend_a.pop_front()); void'(pend_due.pop_front());
      end else if (force_mdv) begin
        memory_data_valid = 1'b1; memory_data = 16'hDEAD;
      end else begin
        memory_data_valid = 1'b0; memory_data = '0;
      end
    end
  end

  task automatic test_reset();
    tick(2);
    tests++;
    if ({fsm_busy, mem_req_valid, write_data_array, write_tag_array, miss_data_valid} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b, expected 00000",
               {fsm_busy, mem_req_valid, write_data_array, write_tag_array, miss_data_valid});
    end
    tests++;
    if (memory_address !== 16'h0 || miss_data !== 16'h0) begin
      fails++;
      $display("FAIL reset_data: addr %h miss_data %h, expected 0000 0000", memory_address, miss_data);
    end
    tests++;
    if ({busy2, req_valid2, tag2, missv2} !== 4'b0 || missd2 !== 32'h0) begin
      fails++;
      $display("FAIL reset_dut2: ctrl %b data %h, expected 0000 00000000",
               {busy2, req_valid2, tag2, missv2}, missd2);
    end
    rst_n = 1'b1;
    tick(2);
    tests++;
    if (fsm_busy !== 1'b0) begin
      fails++; $display("FAIL idle_busy: got %b, expected 0", fsm_busy);
    end
  endtask

  task automatic test_basic_fill();
    int mc;
    clear_logs();
    start_miss(16'h1236, mc);
    wait_tag(1, 60);
    tick(3);
    tests++;
    if (acc_q.size() != 8) begin
      fails++; $display("FAIL basic_req_count: got %0d, expected 8", acc_q.size());
    end
    for (int i = 0; i < 8 && i < acc_q.size(); i++) begin
      tests++;
      if (acc_q[i] !== 16'h1230 + 16'(2 * exp_idx(i, 3, 8))) begin
        fails++;
        $display("FAIL basic_addr[%0d]: got %h, expected %h", i, acc_q[i],
                 16'h1230 + 16'(2 * exp_idx(i, 3, 8)));
      end
    end
    tests++;
    if (acc_cyc_q.size() == 0 || acc_cyc_q[0] != mc + 1) begin
      fails++; $display("FAIL basic_first_req: expected cycle %0d", mc + 1);
    end
    tests++;
    if (wr_idx_q.size() != 8) begin
      fails++; $display("FAIL basic_wr_count: got %0d, expected 8", wr_idx_q.size());
    end
    for (int i = 0; i < 8 && i < wr_idx_q.size(); i++) begin
      tests++;
      if (wr_idx_q[i] != exp_idx(i, 3, 8) ||
          wr_dat_q[i] !== dat(16'h1230 + 16'(2 * exp_idx(i, 3, 8)))) begin
        fails++;
        $display("FAIL basic_wr[%0d]: idx %0d data %h, expected idx %0d data %h", i,
                 wr_idx_q[i], wr_dat_q[i], exp_idx(i, 3, 8),
                 dat(16'h1230 + 16'(2 * exp_idx(i, 3, 8))));
      end
    end
    tests++;
    if (tag_cnt != 1 || tag_cyc != mc + 13) begin
      fails++;
      $display("FAIL basic_tag: count %0d cycle %0d, expected 1 at %0d", tag_cnt, tag_cyc, mc + 13);
    end
    tests++;
    if (busy_hist[mc] !== 1'b0 || busy_hist[mc + 1] !== 1'b1 ||
        busy_hist[mc + 13] !== 1'b1 || busy_hist[mc + 14] !== 1'b0) begin
      fails++;
      $display("FAIL basic_busy: got %b%b%b%b, expected 0110", busy_hist[mc],
               busy_hist[mc + 1], busy_hist[mc + 13], busy_hist[mc + 14]);
    end
    tests++;
    if (mdv_cnt != 1 || mdv_cyc != (CRIT_FIRST ? mc + 5 : mc + 13) || mdv_dat !== dat(16'h1236)) begin
      fails++;
      $display("FAIL basic_miss_data: count %0d cycle %0d data %h, expected 1 at %0d data %h",
               mdv_cnt, mdv_cyc, mdv_dat, CRIT_FIRST ? mc + 5 : mc + 13, dat(16'h1236));
    end
    tests++;
    if (miss_data !== dat(16'h1236)) begin
      fails++; $display("FAIL basic_hold: got %h, expected %h", miss_data, dat(16'h1236));
    end
  endtask

  task automatic test_ready_stall();
    int mc;
    clear_logs();
    ready_mode = 1;
    start_miss(16'h2A42, mc);
    wait_tag(1, 200);
    tick(3);
    ready_mode = 0;
    tests++;
    if (acc_q.size() != 8 || stall_err != 0) begin
      fails++;
      $display("FAIL stall_accepts: count %0d unstable %0d, expected 8 and 0", acc_q.size(), stall_err);
    end
    for (int i = 0; i < 8 && i < acc_q.size(); i++) begin
      tests++;
      if (acc_q[i] !== 16'h2A40 + 16'(2 * exp_idx(i, 1, 8))) begin
        fails++;
        $display("FAIL stall_addr[%0d]: got %h, expected %h", i, acc_q[i],
                 16'h2A40 + 16'(2 * exp_idx(i, 1, 8)));
      end
    end
    for (int i = 0; i < 8 && i < wr_idx_q.size(); i++) begin
      tests++;
      if (wr_idx_q[i] != exp_idx(i, 1, 8)) begin
        fails++;
        $display("FAIL stall_wr[%0d]: got %0d, expected %0d", i, wr_idx_q[i], exp_idx(i, 1, 8));
      end
    end
    tests++;
    if (wr_idx_q.size() != 8 || tag_cnt != 1 || tag_cyc != wr_cyc_q[wr_cyc_q.size() - 1] + 1) begin
      fails++;
      $display("FAIL stall_tag: writes %0d tags %0d, expected 8 writes then 1 tag",
               wr_idx_q.size(), tag_cnt);
    end
  endtask

  task automatic test_reset_midfill();
    int mc;
    int k = 0;
    clear_logs();
    start_miss(16'h4C06, mc);
    while (wr_idx_q.size() < 3 && k < 60) begin tick(1); k++; end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({fsm_busy, mem_req_valid, write_data_array, write_tag_array, miss_data_valid} !== 5'b0 ||
        memory_address !== 16'h0 || miss_data !== 16'h0) begin
      fails++;
      $display("FAIL midfill_reset: ctrl %b addr %h data %h, expected all zero",
               {fsm_busy, mem_req_valid, write_data_array, write_tag_array, miss_data_valid},
               memory_address, miss_data);
    end
    clear_logs();
    tick(2);
    rst_n = 1'b1;
    k = 0;
    while (pend_due.size() > 0 && k < 30) begin tick(1); k++; end
    tick(2);
    tests++;
    if (wr_idx_q.size() != 0 || tag_cnt != 0) begin
      fails++;
      $display("FAIL late_responses: writes %0d tags %0d, expected 0 0", wr_idx_q.size(), tag_cnt);
    end
    clear_logs();
    start_miss(16'hFFFE, mc);
    wait_tag(1, 60);
    tick(2);
    tests++;
    if (acc_q.size() != 8 || tag_cnt != 1) begin
      fails++;
      $display("FAIL top_fill: reqs %0d tags %0d, expected 8 1", acc_q.size(), tag_cnt);
    end
    for (int i = 0; i < 8 && i < acc_q.size(); i++) begin
      tests++;
      if (acc_q[i] !== 16'hFFF0 + 16'(2 * exp_idx(i, 7, 8))) begin
        fails++;
        $display("FAIL top_addr[%0d]: got %h, expected %h", i, acc_q[i],
                 16'hFFF0 + 16'(2 * exp_idx(i, 7, 8)));
      end
    end
  endtask

  task automatic test_idle_and_held_miss();
    int t1;
    clear_logs();
    force_mdv = 1'b1;
    tick(3);
    force_mdv = 1'b0;
    tick(2);
    tests++;
    if (wr_idx_q.size() != 0 || fsm_busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_response: writes %0d busy %b, expected 0 0", wr_idx_q.size(), fsm_busy);
    end
    miss_address  = 16'h3010;
    miss_detected = 1'b1;
    wait_tag(1, 60);
    t1 = tag_cyc;
    tick(1);
    miss_detected = 1'b0;
    tests++;
    if (acc_q.size() != 8 || tag_cnt != 1) begin
      fails++;
      $display("FAIL held_single_fill: reqs %0d tags %0d, expected 8 1", acc_q.size(), tag_cnt);
    end
    wait_tag(2, 60);
    tick(3);
    tests++;
    if (tag_cnt != 2 || acc_q.size() != 16 || wr_idx_q.size() != 16) begin
      fails++;
      $display("FAIL held_refill: tags %0d reqs %0d writes %0d, expected 2 16 16",
               tag_cnt, acc_q.size(), wr_idx_q.size());
    end
    tests++;
    if (busy_hist[t1 + 1] !== 1'b0 || busy_hist[t1 + 2] !== 1'b1 ||
        acc_cyc_q.size() < 9 || acc_cyc_q[8] != t1 + 2) begin
      fails++;
      $display("FAIL held_restart: busy %b%b, expected 01 and second fill request at %0d",
               busy_hist[t1 + 1], busy_hist[t1 + 2], t1 + 2);
    end
  endtask

  task automatic test_words4();
    logic [15:0] a_q[$];
    logic [15:0] p_q[$];
    int          due_q[$];
    int          w_q[$];
    int          c = 0;
    int          tags = 0;
    int          mvs = 0;
    logic [31:0] mval = '0;
    miss_address2  = 16'h0108;
    miss_detected2 = 1'b1;
    tick(1);
    miss_detected2 = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (req_valid2 && req_ready2) begin
        a_q.push_back(addr2); p_q.push_back(addr2); due_q.push_back(c + LAT);
      end
      if (wr2) w_q.push_back(int'(widx2));
      if (tag2) tags++;
      if (missv2) begin mvs++; mval = missd2; end
      @(posedge clk);
      c++;
      #1;
      if (due_q.size() > 0 && due_q[0] <= c) begin
        mdv_in2 = 1'b1; mdata2 = {16'hBEEF, p_q[0]};
        void'(p_q.pop_front()); void'(due_q.pop_front());
      end else begin
        mdv_in2 = 1'b0; mdata2 = '0;
      end
    end
    tests++;
    if (a_q.size() != 4 || w_q.size() != 4 || tags != 1) begin
      fails++;
      $display("FAIL w4_counts: reqs %0d writes %0d tags %0d, expected 4 4 1",
               a_q.size(), w_q.size(), tags);
    end
    for (int i = 0; i < 4 && i < a_q.size() && i < w_q.size(); i++) begin
      tests++;
      if (a_q[i] !== 16'h0100 + 16'(4 * exp_idx(i, 2, 4)) || w_q[i] != exp_idx(i, 2, 4)) begin
        fails++;
        $display("FAIL w4_req[%0d]: addr %h idx %0d, expected %h %0d", i, a_q[i], w_q[i],
                 16'h0100 + 16'(4 * exp_idx(i, 2, 4)), exp_idx(i, 2, 4));
      end
    end
    tests++;
    if (mvs != 1 || mval !== 32'hBEEF0108) begin
      fails++;
      $display("FAIL w4_miss_data: pulses %0d data %h, expected 1 beef0108", mvs, mval);
    end
  endtask

  initial begin
    miss_detected = 1'b0; miss_address = '0;
    miss_detected2 = 1'b0; miss_address2 = '0;
    req_ready2 = 1'b1; mdv_in2 = 1'b0; mdata2 = '0;
    clear_logs();
    test_reset();
    test_basic_fill();
    test_ready_stall();
    test_reset_midfill();
    test_idle_and_held_miss();
    test_words4();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
